// File: rtl/id_ex_reg_pkg.sv
// Shared CPU pipeline definitions: data width, ALU-op width and the
// encodings for the EX-stage operand-mux selects.
package id_ex_reg_pkg;

  localparam int DATA_SIZE  = 32;
  localparam int ALU_OP_W   = 4;
  localparam int REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    FWD_REG   = 2'b00,
    FWD_EXMEM = 2'b01,
    FWD_MEMWB = 2'b10,
    FWD_ALT   = 2'b11
  } fwd_sel_e;

endpackage

// File: rtl/id_ex_reg_fwd_sel_gen.sv
// Combinational forwarding-select generator for one EX operand.
// Priority: alternate source, then younger EX producer, then MEM producer.
module fwd_sel_gen
  import id_ex_reg_pkg::*;
(
  input  logic                  i_use_rs,
  input  logic [REG_ADDR_W-1:0] i_rs_addr,
  input  logic                  i_alt,
  input  logic                  i_ex_valid,
  input  logic                  i_ex_reg_write,
  input  logic [REG_ADDR_W-1:0] i_ex_rd_addr,
  input  logic                  i_mem_valid,
  input  logic                  i_mem_reg_write,
  input  logic [REG_ADDR_W-1:0] i_mem_rd_addr,
  output fwd_sel_e              o_sel
);

  logic w_ex_hit;
  logic w_mem_hit;

  // x0 is hardwired, so a zero destination never forwards
  assign w_ex_hit  = i_use_rs & i_ex_valid & i_ex_reg_write &
                     (i_ex_rd_addr != '0) & (i_ex_rd_addr == i_rs_addr);
  assign w_mem_hit = i_use_rs & i_mem_valid & i_mem_reg_write &
                     (i_mem_rd_addr != '0) & (i_mem_rd_addr == i_rs_addr);

  always_comb begin
    o_sel = FWD_REG;
    if (i_alt)          o_sel = FWD_ALT;
    else if (w_ex_hit)  o_sel = FWD_EXMEM;
    else if (w_mem_hit) o_sel = FWD_MEMWB;
  end

endmodule

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with forwarding-select precompute and load-use detect.
// One-cycle latency; stall_i holds all state, flush_i or a load-use hazard inserts a bubble.
module id_ex_reg
  import id_ex_reg_pkg::*;
#(
  parameter int DATA_W = DATA_SIZE
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall_i,
  input  logic                  flush_i,
  input  logic                  id_valid,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  id_mem_write,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic                  id_use_pc,
  input  logic                  id_alu_src,
  input  logic [DATA_W-1:0]     id_pc,
  input  logic [DATA_W-1:0]     id_rs1_data,
  input  logic [DATA_W-1:0]     id_rs2_data,
  input  logic [DATA_W-1:0]     id_imm,
  input  logic [REG_ADDR_W-1:0] id_rs1_addr,
  input  logic [REG_ADDR_W-1:0] id_rs2_addr,
  input  logic [REG_ADDR_W-1:0] id_rd_addr,
  input  logic [ALU_OP_W-1:0]   id_alu_op,
  input  logic                  mem_valid,
  input  logic                  mem_reg_write,
  input  logic [REG_ADDR_W-1:0] mem_rd_addr,
  output logic                  ex_valid,
  output logic                  ex_reg_write,
  output logic                  ex_mem_read,
  output logic                  ex_mem_write,
  output logic                  ex_use_rs1,
  output logic                  ex_use_rs2,
  output logic                  ex_use_pc,
  output logic                  ex_alu_src,
  output logic [DATA_W-1:0]     ex_pc,
  output logic [DATA_W-1:0]     ex_rs1_data,
  output logic [DATA_W-1:0]     ex_rs2_data,
  output logic [DATA_W-1:0]     ex_imm,
  output logic [REG_ADDR_W-1:0] ex_rs1_addr,
  output logic [REG_ADDR_W-1:0] ex_rs2_addr,
  output logic [REG_ADDR_W-1:0] ex_rd_addr,
  output logic [ALU_OP_W-1:0]   ex_alu_op,
  output logic [1:0]            ex_fwd_sel_a,
  output logic [1:0]            ex_fwd_sel_b,
  output logic                  load_use_hazard
);

  logic                  r_valid, r_reg_write, r_mem_read, r_mem_write;
  logic                  r_use_rs1, r_use_rs2, r_use_pc, r_alu_src;
  logic [DATA_W-1:0]     r_pc, r_rs1_data, r_rs2_data, r_imm;
  logic [REG_ADDR_W-1:0] r_rs1_addr, r_rs2_addr, r_rd_addr;
  logic [ALU_OP_W-1:0]   r_alu_op;
  fwd_sel_e              r_fwd_sel_a, r_fwd_sel_b;

  fwd_sel_e w_sel_a, w_sel_b;
  logic     w_hazard, w_bubble;

  fwd_sel_gen u_sel_a (
    .i_use_rs       (id_use_rs1),
    .i_rs_addr      (id_rs1_addr),
    .i_alt          (id_use_pc),
    .i_ex_valid     (r_valid),
    .i_ex_reg_write (r_reg_write),
    .i_ex_rd_addr   (r_rd_addr),
    .i_mem_valid    (mem_valid),
    .i_mem_reg_write(mem_reg_write),
    .i_mem_rd_addr  (mem_rd_addr),
    .o_sel          (w_sel_a)
  );

  fwd_sel_gen u_sel_b (
    .i_use_rs       (id_use_rs2),
    .i_rs_addr      (id_rs2_addr),
    .i_alt          (id_alu_src),
    .i_ex_valid     (r_valid),
    .i_ex_reg_write (r_reg_write),
    .i_ex_rd_addr   (r_rd_addr),
    .i_mem_valid    (mem_valid),
    .i_mem_reg_write(mem_reg_write),
    .i_mem_rd_addr  (mem_rd_addr),
    .o_sel          (w_sel_b)
  );

  // A load in EX cannot forward until MEM, so its dependants must wait a cycle
  assign w_hazard = id_valid & r_valid & r_mem_read & (r_rd_addr != '0) &
                    ((id_use_rs1 & (r_rd_addr == id_rs1_addr)) |
                     (id_use_rs2 & (r_rd_addr == id_rs2_addr)));
  assign w_bubble = flush_i | w_hazard;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid     <= 1'b0;
      r_reg_write <= 1'b0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_use_rs1   <= 1'b0;
      r_use_rs2   <= 1'b0;
      r_use_pc    <= 1'b0;
      r_alu_src   <= 1'b0;
      r_pc        <= '0;
      r_rs1_data  <= '0;
      r_rs2_data  <= '0;
      r_imm       <= '0;
      r_rs1_addr  <= '0;
      r_rs2_addr  <= '0;
      r_rd_addr   <= '0;
      r_alu_op    <= '0;
      r_fwd_sel_a <= FWD_REG;
      r_fwd_sel_b <= FWD_REG;
    end else if (!stall_i) begin
      if (w_bubble) begin
        // operand fields keep their old values; only the qualifiers drop
        r_valid     <= 1'b0;
        r_reg_write <= 1'b0;
        r_mem_read  <= 1'b0;
        r_mem_write <= 1'b0;
        r_fwd_sel_a <= FWD_REG;
        r_fwd_sel_b <= FWD_REG;
      end else begin
        r_valid     <= id_valid;
        r_reg_write <= id_valid & id_reg_write;
        r_mem_read  <= id_valid & id_mem_read;
        r_mem_write <= id_valid & id_mem_write;
        r_fwd_sel_a <= id_valid ? w_sel_a : FWD_REG;
        r_fwd_sel_b <= id_valid ? w_sel_b : FWD_REG;
        r_use_rs1   <= id_use_rs1;
        r_use_rs2   <= id_use_rs2;
        r_use_pc    <= id_use_pc;
        r_alu_src   <= id_alu_src;
        r_pc        <= id_pc;
        r_rs1_data  <= id_rs1_data;
        r_rs2_data  <= id_rs2_data;
        r_imm       <= id_imm;
        r_rs1_addr  <= id_rs1_addr;
        r_rs2_addr  <= id_rs2_addr;
        r_rd_addr   <= id_rd_addr;
        r_alu_op    <= id_alu_op;
      end
    end
  end

  assign ex_valid        = r_valid;
  assign ex_reg_write    = r_reg_write;
  assign ex_mem_read     = r_mem_read;
  assign ex_mem_write    = r_mem_write;
  assign ex_use_rs1      = r_use_rs1;
  assign ex_use_rs2      = r_use_rs2;
  assign ex_use_pc       = r_use_pc;
  assign ex_alu_src      = r_alu_src;
  assign ex_pc           = r_pc;
  assign ex_rs1_data     = r_rs1_data;
  assign ex_rs2_data     = r_rs2_data;
  assign ex_imm          = r_imm;
  assign ex_rs1_addr     = r_rs1_addr;
  assign ex_rs2_addr     = r_rs2_addr;
  assign ex_rd_addr      = r_rd_addr;
  assign ex_alu_op       = r_alu_op;
  assign ex_fwd_sel_a    = r_fwd_sel_a;
  assign ex_fwd_sel_b    = r_fwd_sel_b;
  assign load_use_hazard = w_hazard;

endmodule

// File: tb/tb_id_ex_reg.sv
// Bench for id_ex_reg: directed pipeline scenarios plus randomized traffic,
// all checked against a transaction-level model of the EX slot.
module tb_id_ex_reg;

  typedef struct packed {
    logic        valid, reg_write, mem_read, mem_write;
    logic        use_rs1, use_rs2, use_pc, alu_src;
    logic [31:0] pc, rs1_data, rs2_data, imm;
    logic [4:0]  rs1_addr, rs2_addr, rd_addr;
    logic [3:0]  alu_op;
  } id_t;

  typedef struct packed {
    id_t        ins;
    logic [1:0] sel_a, sel_b;
  } ex_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic stall_i = 1'b0, flush_i = 1'b0;
  logic mem_valid = 1'b0, mem_reg_write = 1'b0;
  logic [4:0] mem_rd_addr = '0;
  id_t id_in = '0;
  ex_t exp_q = '0;
  ex_t obs;
  ex_t snap;
  int  pass_cnt = 0;
  int  total_cnt = 0;

  logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write;
  logic        ex_use_rs1, ex_use_rs2, ex_use_pc, ex_alu_src;
  logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0]  ex_rs1_addr, ex_rs2_addr, ex_rd_addr;
  logic [3:0]  ex_alu_op;
  logic [1:0]  ex_fwd_sel_a, ex_fwd_sel_b;
  logic        load_use_hazard;

  always #5 clk = ~clk;

  id_ex_reg #(.DATA_W(32)) dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i),
    .id_valid(id_in.valid), .id_reg_write(id_in.reg_write),
    .id_mem_read(id_in.mem_read), .id_mem_write(id_in.mem_write),
    .id_use_rs1(id_in.use_rs1), .id_use_rs2(id_in.use_rs2),
    .id_use_pc(id_in.use_pc), .id_alu_src(id_in.alu_src),
    .id_pc(id_in.pc), .id_rs1_data(id_in.rs1_data), .id_rs2_data(id_in.rs2_data),
    .id_imm(id_in.imm), .id_rs1_addr(id_in.rs1_addr), .id_rs2_addr(id_in.rs2_addr),
    .id_rd_addr(id_in.rd_addr), .id_alu_op(id_in.alu_op),
    .mem_valid(mem_valid), .mem_reg_write(mem_reg_write), .mem_rd_addr(mem_rd_addr),
    .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_use_rs1(ex_use_rs1), .ex_use_rs2(ex_use_rs2),
    .ex_use_pc(ex_use_pc), .ex_alu_src(ex_alu_src), .ex_pc(ex_pc),
    .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
    .ex_rs1_addr(ex_rs1_addr), .ex_rs2_addr(ex_rs2_addr), .ex_rd_addr(ex_rd_addr),
    .ex_alu_op(ex_alu_op), .ex_fwd_sel_a(ex_fwd_sel_a), .ex_fwd_sel_b(ex_fwd_sel_b),
    .load_use_hazard(load_use_hazard)
  );

  assign obs = {ex_valid, ex_reg_write, ex_mem_read, ex_mem_write,
                ex_use_rs1, ex_use_rs2, ex_use_pc, ex_alu_src,
                ex_pc, ex_rs1_data, ex_rs2_data, ex_imm,
                ex_rs1_addr, ex_rs2_addr, ex_rd_addr, ex_alu_op,
                ex_fwd_sel_a, ex_fwd_sel_b};

  // Where does operand X come from, given what is in flight ahead of it?
  function automatic logic [1:0] m_sel(logic alt, logic use_rs, logic [4:0] a, ex_t e);
    if (alt) return 2'd3;
    if (use_rs && a != 0 && e.ins.valid && e.ins.reg_write && e.ins.rd_addr == a) return 2'd1;
    if (use_rs && a != 0 && mem_valid && mem_reg_write && mem_rd_addr == a) return 2'd2;
    return 2'd0;
  endfunction

  function automatic logic m_haz(ex_t e, id_t d);
    logic dep;
    dep = (d.use_rs1 && d.rs1_addr == e.ins.rd_addr) || (d.use_rs2 && d.rs2_addr == e.ins.rd_addr);
    return d.valid && e.ins.valid && e.ins.mem_read && e.ins.rd_addr != 0 && dep;
  endfunction

  function automatic ex_t m_next(ex_t e, id_t d);
    ex_t n;
    n = e;
    if (!rst) return '0;
    if (stall_i) return e;
    if (flush_i || m_haz(e, d)) begin
      {n.ins.valid, n.ins.reg_write, n.ins.mem_read, n.ins.mem_write} = '0;
      n.sel_a = 2'd0;
      n.sel_b = 2'd0;
      return n;
    end
    n.ins = d;
    if (d.valid) begin
      n.sel_a = m_sel(d.use_pc, d.use_rs1, d.rs1_addr, e);
      n.sel_b = m_sel(d.alu_src, d.use_rs2, d.rs2_addr, e);
    end else begin
      {n.ins.reg_write, n.ins.mem_read, n.ins.mem_write} = '0;
      n.sel_a = 2'd0;
      n.sel_b = 2'd0;
    end
    return n;
  endfunction

  function automatic id_t alu(int rd, int rs1, int rs2);
    id_t d;
    d = '0;
    d.valid = 1'b1; d.reg_write = 1'b1; d.use_rs1 = 1'b1; d.use_rs2 = 1'b1;
    d.pc = $urandom; d.rs1_data = $urandom; d.rs2_data = $urandom; d.imm = $urandom;
    d.rs1_addr = 5'(rs1); d.rs2_addr = 5'(rs2); d.rd_addr = 5'(rd);
    d.alu_op = 4'($urandom_range(0, 15));
    return d;
  endfunction

  function automatic id_t lw(int rd, int rs1);
    id_t d;
    d = alu(rd, rs1, 0);
    d.use_rs2 = 1'b0; d.alu_src = 1'b1; d.mem_read = 1'b1;
    return d;
  endfunction

  task automatic tick();
    ex_t n;
    n = m_next(exp_q, id_in);
    @(posedge clk);
    #1;
    exp_q = n;
  endtask

  task automatic set_mem(logic v, logic w, int rd);
    mem_valid = v; mem_reg_write = w; mem_rd_addr = 5'(rd);
  endtask

  task automatic test_reset();
    #2 rst = 1'b0;
    #1;
    exp_q = '0;
    id_in = alu(1, 2, 3);
    tick();
    total_cnt++;
    if (obs !== 0) $display("FAIL reset_state got=%h exp=0", obs); else pass_cnt++;
    total_cnt++;
    if (load_use_hazard !== 1'b0) $display("FAIL reset_hazard got=%b exp=0", load_use_hazard); else pass_cnt++;
    #2 rst = 1'b1;
    tick();
    total_cnt++;
    if (obs !== exp_q || ex_valid !== 1'b1) $display("FAIL reset_release got=%h exp=%h", obs, exp_q); else pass_cnt++;
  endtask

  task automatic test_dependent_alu();
    set_mem(0, 0, 0);
    id_in = alu(5, 3, 4);
    tick();
    id_in = alu(6, 5, 1);
    #1;
    total_cnt++;
    if (load_use_hazard !== 1'b0) $display("FAIL dep_hazard got=%b exp=0", load_use_hazard); else pass_cnt++;
    tick();
    total_cnt++;
    if (obs !== exp_q || ex_fwd_sel_a !== 2'b01 || ex_fwd_sel_b !== 2'b00)
      $display("FAIL dep_alu got=%h exp=%h", obs, exp_q);
    else pass_cnt++;
  endtask

  task automatic test_load_use();
    set_mem(0, 0, 0);
    id_in = lw(7, 2);
    tick();
    id_in = alu(8, 7, 7);
    #1;
    total_cnt++;
    if (load_use_hazard !== 1'b1) $display("FAIL lu_hazard got=%b exp=1", load_use_hazard); else pass_cnt++;
    tick();
    set_mem(1, 1, 7);
    total_cnt++;
    if (obs !== exp_q || ex_valid !== 1'b0) $display("FAIL lu_bubble got=%h exp=%h", obs, exp_q); else pass_cnt++;
    #1;
    total_cnt++;
    if (load_use_hazard !== 1'b0) $display("FAIL lu_clear got=%b exp=0", load_use_hazard); else pass_cnt++;
    tick();
    total_cnt++;
    if (obs !== exp_q || ex_fwd_sel_a !== 2'b10 || ex_fwd_sel_b !== 2'b10)
      $display("FAIL lu_capture got=%h exp=%h", obs, exp_q);
    else pass_cnt++;
  endtask

  task automatic test_ex_mem_same();
    set_mem(0, 0, 0);
    id_in = alu(3, 1, 2);
    tick();
    set_mem(1, 1, 3);
    id_in = alu(9, 3, 3);
    tick();
    total_cnt++;
    if (obs !== exp_q || ex_fwd_sel_a !== 2'b01 || ex_fwd_sel_b !== 2'b01)
      $display("FAIL ex_wins got=%h exp=%h", obs, exp_q);
    else pass_cnt++;
    set_mem(1, 1, 0);
    id_in = alu(0, 1, 2);
    tick();
    id_in = alu(9, 0, 0);
    tick();
    total_cnt++;
    if (obs !== exp_q || ex_fwd_sel_a !== 2'b00 || ex_fwd_sel_b !== 2'b00)
      $display("FAIL x0_nohit got=%h exp=%h", obs, exp_q);
    else pass_cnt++;
  endtask

  task automatic test_stall();
    set_mem(0, 0, 0);
    id_in = lw(4, 1);
    tick();
    snap = obs;
    stall_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      id_in = alu($urandom_range(0, 5), $urandom_range(3, 5), $urandom_range(3, 5));
      flush_i = (i == 2);
      #1;
      total_cnt++;
      if (load_use_hazard !== m_haz(exp_q, id_in))
        $display("FAIL stall_hazard[%0d] got=%b exp=%b", i, load_use_hazard, m_haz(exp_q, id_in));
      else pass_cnt++;
      tick();
      total_cnt++;
      if (obs !== snap || obs !== exp_q) $display("FAIL stall_hold[%0d] got=%h exp=%h", i, obs, snap); else pass_cnt++;
    end
    stall_i = 1'b0;
    flush_i = 1'b0;
    id_in = alu(10, 11, 12);
    tick();
    total_cnt++;
    if (obs !== exp_q || ex_rd_addr !== 5'd10 || ex_valid !== 1'b1)
      $display("FAIL stall_release got=%h exp=%h", obs, exp_q);
    else pass_cnt++;
  endtask

  task automatic test_flush_hazard();
    set_mem(0, 0, 0);
    id_in = lw(7, 1);
    tick();
    id_in = alu(8, 7, 7);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    total_cnt++;
    if (obs !== exp_q || ex_valid !== 1'b0) $display("FAIL flush_bubble got=%h exp=%h", obs, exp_q); else pass_cnt++;
    set_mem(1, 1, 7);
    #1;
    total_cnt++;
    if (load_use_hazard !== 1'b0) $display("FAIL flush_reeval got=%b exp=0", load_use_hazard); else pass_cnt++;
    tick();
    total_cnt++;
    if (obs !== exp_q || ex_valid !== 1'b1 || ex_fwd_sel_a !== 2'b10)
      $display("FAIL flush_next got=%h exp=%h", obs, exp_q);
    else pass_cnt++;
    id_in = alu(8, 8, 8);
    id_in.use_rs1 = 1'b0; id_in.use_rs2 = 1'b0; id_in.use_pc = 1'b1; id_in.alu_src = 1'b1;
    tick();
    total_cnt++;
    if (obs !== exp_q || ex_fwd_sel_a !== 2'b11 || ex_fwd_sel_b !== 2'b11)
      $display("FAIL auipc_sel got=%h exp=%h", obs, exp_q);
    else pass_cnt++;
  endtask

  task automatic test_async_reset();
    set_mem(0, 0, 0);
    id_in = alu(13, 1, 2);
    tick();
    id_in = alu(14, 13, 13);
    tick();
    stall_i = 1'b1;
    #3 rst = 1'b0;
    #1;
    exp_q = '0;
    total_cnt++;
    if (obs !== 0) $display("FAIL async_reset got=%h exp=0", obs); else pass_cnt++;
    #2 rst = 1'b1;
    stall_i = 1'b0;
    id_in = alu(15, 1, 2);
    tick();
    total_cnt++;
    if (obs !== exp_q || ex_rd_addr !== 5'd15) $display("FAIL async_release got=%h exp=%h", obs, exp_q); else pass_cnt++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      id_in = alu($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
      id_in.valid = ($urandom_range(0, 7) != 0);
      id_in.reg_write = $urandom_range(0, 3) != 0;
      id_in.mem_read = $urandom_range(0, 2) == 0;
      id_in.mem_write = $urandom_range(0, 4) == 0;
      id_in.use_rs1 = $urandom_range(0, 4) != 0;
      id_in.use_rs2 = $urandom_range(0, 2) != 0;
      id_in.use_pc = $urandom_range(0, 7) == 0;
      id_in.alu_src = $urandom_range(0, 3) == 0;
      stall_i = $urandom_range(0, 9) == 0;
      flush_i = $urandom_range(0, 9) == 0;
      set_mem($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 3));
      #1;
      total_cnt++;
      if (load_use_hazard !== m_haz(exp_q, id_in))
        $display("FAIL rnd_hazard[%0d] got=%b exp=%b", i, load_use_hazard, m_haz(exp_q, id_in));
      else pass_cnt++;
      tick();
      total_cnt++;
      if (obs !== exp_q) $display("FAIL rnd_state[%0d] got=%h exp=%h", i, obs, exp_q); else pass_cnt++;
    end
    stall_i = 1'b0;
    flush_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_dependent_alu();
    test_load_use();
    test_ex_mem_same();
    test_stall();
    test_flush_hazard();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/id_ex_reg.md
ID_EX_REG -- requirements
Module: id_ex_reg

Interface
REQ-001 Parameter DATA_W, default `data_size (32), width of every data/PC/immediate path.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 stall_i  input  1  global freeze (I/D-cache miss); the register holds all state.
REQ-005 flush_i  input  1  branch/jump redirect; the next EX slot becomes a bubble.
REQ-006 id_valid, id_reg_write, id_mem_read, id_mem_write, id_use_rs1, id_use_rs2, id_use_pc, id_alu_src  input  1 each  ID-stage qualifiers and controls.
REQ-007 id_pc, id_rs1_data, id_rs2_data, id_imm  input  DATA_W each  ID-stage operands.
REQ-008 id_rs1_addr, id_rs2_addr, id_rd_addr  input  5 each  register indices.
REQ-009 id_alu_op  input  4  ALU operation code.
REQ-010 mem_valid, mem_reg_write  input  1 each; mem_rd_addr  input  5: instruction currently in MEM.
REQ-011 ex_* outputs: registered copies of every id_* signal in REQ-006..009, same widths.
REQ-012 ex_fwd_sel_a, ex_fwd_sel_b  output  2 each  registered selects for the EX 4-input operand muxes.
REQ-013 load_use_hazard  output  1  combinational; the IF/ID stage holds while high.

Function
REQ-014 Select encoding: 00 = ex_rs*_data, 01 = EX/MEM ALU result, 10 = MEM/WB write-back data, 11 = ex_pc (A) or ex_imm (B).
REQ-015 ex_fwd_sel_a is computed from ID-stage inputs at each capture, with priority: id_use_pc -> 11; EX hit -> 01; MEM hit -> 10; else 00.
REQ-016 ex_fwd_sel_b uses the same priority, with id_alu_src -> 11 in place of id_use_pc.
REQ-017 EX hit: ex_valid & ex_reg_write & ex_rd_addr!=0 & ex_rd_addr==id_rsX_addr & id_use_rsX.
REQ-018 MEM hit: mem_valid & mem_reg_write & mem_rd_addr!=0 & mem_rd_addr==id_rsX_addr & id_use_rsX.
REQ-019 If the EX and MEM hits target the same register, the EX hit (younger) wins.
REQ-020 Register x0 never produces a hit.
REQ-021 load_use_hazard = id_valid & ex_valid & ex_mem_read & ex_rd_addr!=0 & ((id_use_rs1 & ex_rd_addr==id_rs1_addr) | (id_use_rs2 & ex_rd_addr==id_rs2_addr)).
REQ-022 Edge priority is: stall_i high -> hold everything.
REQ-023 Otherwise, if flush_i or load_use_hazard is high -> insert a bubble.
REQ-024 Otherwise -> capture the ID inputs.
REQ-025 A bubble sets ex_valid, ex_reg_write, ex_mem_read and ex_mem_write to 0 and both fwd selects to 00; data fields are don't-care but SHALL be held.
REQ-026 Latency is 1 cycle from ID inputs to ex_* outputs, with no combinational path from id_* to ex_*.
REQ-027 An input with id_valid=0 is captured with its control bits forced to 0, so it behaves identically to a bubble.
REQ-028 flush_i together with a load-use hazard produces one bubble only; the hazard re-evaluates next cycle.
REQ-029 Any stall_i hold duration preserves all outputs, with load_use_hazard still tracking inputs.
REQ-030 A write-back to the same register in the current ID cycle is outside this block; the register-file write-first bypass resolves it.

Reset
REQ-031 On rst low, all ex_* outputs are cleared to 0 and both fwd selects to 00, asynchronously.
REQ-032 Reset takes effect mid-stall or mid-flush and overrides both.
REQ-033 Release is synchronous to clk; the first edge after release captures normally.

Structure
REQ-034 The fwd-select encodings (FWD_REG, FWD_EXMEM, FWD_MEMWB, FWD_ALT) and the ALU-op width belong in the shared CPU package.
REQ-035 One sub-module, fwd_sel_gen, is combinational and instantiated twice (A, B); it computes one select from rs addr/use, alt flag, and EX/MEM destination info.

Verification
REQ-036 Back-to-back dependent ALU ops: add x5 then sub x6,x5,x1 -> ex_fwd_sel_a=01, ex_fwd_sel_b=00, no hazard.
REQ-037 lw x7 in EX, ID add x8,x7,x7 -> load_use_hazard=1, next edge ex_valid=0; next capture sel_a=sel_b=10.
REQ-038 EX and MEM both write x3, ID reads x3 -> sel=01; a destination of x0 -> sel=00.
REQ-039 stall_i=1 for 5 cycles with flush_i pulsed -> outputs unchanged throughout; after release with flush_i=0 -> normal capture.
REQ-040 flush_i=1 with load-use pending -> a single bubble, then the hazard re-evaluates; an auipc-type op (id_use_pc=1, id_alu_src=1) -> sel_a=11, sel_b=11.
REQ-041 rst asserted mid-stream, asynchronously to clk -> all outputs 0 immediately; first capture after release is correct.
